// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlap control and a saturating hit counter.
// Define SEQDET_STICKY_EN to add the sticky alarm output and its alarm_clr input.
module seq_pattern_detector #(
    parameter int                     PATTERN_LEN     = 4,
    parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = {PATTERN_LEN{1'b1}},
    parameter int                     COUNT_W         = 8,
    parameter int                     FILL_W          = $clog2(PATTERN_LEN + 1)
) (
    input  logic                   clock,
    input  logic                   resetn,
`ifdef SEQDET_STICKY_EN
    input  logic                   alarm_clr,
    output logic                   alarm,
`endif
    input  logic                   en,
    input  logic                   w,
    input  logic                   overlap,
    input  logic                   load,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    input  logic                   count_clr,
    output logic                   match,
    output logic [FILL_W-1:0]      fill,
    output logic [COUNT_W-1:0]     match_count
);

    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_LEN);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic {FILLING, ARMED} fill_state_e;

    // The oldest history bit is shifted out before every compare, so only N-1 bits are kept.
    logic [PATTERN_LEN-2:0] history_q, history_d;
    logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   match_q, match_d;
    logic [COUNT_W-1:0]     count_q, count_d;

    logic [PATTERN_LEN-1:0] hist_next;
    logic [FILL_W-1:0]      fill_next;
    fill_state_e            state_next;
    logic                   hit;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        history_d  = history_q;
        pattern_d  = pattern_q;
        fill_d     = fill_q;
        match_d    = 1'b0;
        count_d    = count_q;
        hit        = 1'b0;

        hist_next  = {history_q, w};
        fill_next  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        state_next = (fill_next == FILL_FULL) ? ARMED : FILLING;

        if (load) begin
            pattern_d = pattern_in;
            history_d = '0;
            fill_d    = '0;
        end else if (en) begin
            hit       = (state_next == ARMED) && (hist_next == pattern_q);
            match_d   = hit;
            history_d = hist_next[PATTERN_LEN-2:0];
            fill_d    = (hit && !overlap) ? '0 : fill_next;
        end

        if (count_clr) begin
            count_d = hit ? COUNT_W'(1) : '0;
        end else if (hit && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!resetn) begin
            history_q <= '0;
            pattern_q <= DEFAULT_PATTERN;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            history_q <= history_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    assign match       = match_q;
    assign fill        = fill_q;
    assign match_count = count_q;

`ifdef SEQDET_STICKY_EN
    logic alarm_q, alarm_d;

    // A hit wins over a simultaneous clear so no event is lost.
    always_comb begin
        alarm_d = alarm_q;
        if (hit) begin
            alarm_d = 1'b1;
        end else if (alarm_clr) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed-vector bench for seq_pattern_detector; a second instance with COUNT_W=2 covers counter saturation.
module tb_seq_pattern_detector;

    logic       clock = 1'b0;
    logic       resetn;
    logic       en, w, overlap, load, count_clr;
    logic [3:0] pattern_in;
    logic       match, match_s;
    logic [2:0] fill, fill_s;
    logic [7:0] match_count;
    logic [1:0] count_s;
`ifdef SEQDET_STICKY_EN
    logic       alarm_clr, alarm, alarm_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_pattern_detector #(.PATTERN_LEN(4), .COUNT_W(8)) dut (
        .clock(clock), .resetn(resetn),
`ifdef SEQDET_STICKY_EN
        .alarm_clr(alarm_clr), .alarm(alarm),
`endif
        .en(en), .w(w), .overlap(overlap), .load(load), .pattern_in(pattern_in),
        .count_clr(count_clr), .match(match), .fill(fill), .match_count(match_count)
    );

    seq_pattern_detector #(.PATTERN_LEN(4), .COUNT_W(2)) dut_sat (
        .clock(clock), .resetn(resetn),
`ifdef SEQDET_STICKY_EN
        .alarm_clr(alarm_clr), .alarm(alarm_s),
`endif
        .en(en), .w(w), .overlap(overlap), .load(load), .pattern_in(pattern_in),
        .count_clr(count_clr), .match(match_s), .fill(fill_s), .match_count(count_s)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one clock edge with the given en/w, then settle 1ns past the edge.
    task automatic cycle(input logic e, input logic b);
        en = e;
        w  = b;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        en = 1'b0; load = 1'b0; count_clr = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic do_load(input logic [3:0] p, input logic clr);
        load = 1'b1; pattern_in = p; count_clr = clr;
        cycle(1'b1, 1'b1);
        load = 1'b0; count_clr = 1'b0;
    endtask

    logic [6:0] stream_a = 7'b1101101;
    logic [6:0] exp_ovl  = 7'b0001001;
    logic [7:0] exp_nov  = 8'b00010001;
    logic [2:0] exp_fill [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    initial begin
`ifdef SEQDET_STICKY_EN
        alarm_clr = 1'b0;
`endif
        w = 1'b0; overlap = 1'b1; pattern_in = 4'b0000;
        do_reset();
        check("reset_match", match, 0);
        check("reset_fill", fill, 0);
        check("reset_count", match_count, 0);

        // Overlap, default pattern 1111, six 1s.
        overlap = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 1'b1);
            check($sformatf("ovl_ones_match_%0d", k), match, (k >= 4) ? 1 : 0);
        end
        check("ovl_ones_count", match_count, 3);
        check("ovl_ones_fill", fill, 4);

        // Non-overlap, eight 1s.
        do_reset();
        overlap = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1);
            check($sformatf("nov_ones_match_%0d", k + 1), match, exp_nov[7-k]);
            check($sformatf("nov_ones_fill_%0d", k + 1), fill, exp_fill[k]);
        end
        check("nov_ones_count", match_count, 2);

        // Loaded pattern 1101; en/w on the load edge must be ignored.
        do_reset();
        overlap = 1'b1;
        do_load(4'b1101, 1'b0);
        check("load_fill", fill, 0);
        check("load_match", match, 0);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, stream_a[6-k]);
            check($sformatf("p1101_ovl_match_%0d", k + 1), match, exp_ovl[6-k]);
        end
        check("p1101_ovl_count", match_count, 2);

        overlap = 1'b0;
        do_load(4'b1101, 1'b1);
        check("load_clr_count", match_count, 0);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, stream_a[6-k]);
            check($sformatf("p1101_nov_match_%0d", k + 1), match, (k == 3) ? 1 : 0);
        end
        check("p1101_nov_count", match_count, 1);
        check("p1101_nov_fill", fill, 3);

        // Idle cycles hold fill and history.
        do_reset();
        overlap = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0);
            check($sformatf("idle_fill_%0d", k), fill, 2);
            check($sformatf("idle_match_%0d", k), match, 0);
        end
        cycle(1'b1, 1'b1);
        check("idle_resume_match3", match, 0);
        check("idle_resume_fill3", fill, 3);
        cycle(1'b1, 1'b1);
        check("idle_resume_match4", match, 1);

        // Saturation on the 2-bit counter.
        do_reset();
        overlap = 1'b1;
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1);
        check("sat_count", count_s, 3);
        check("wide_count", match_count, 7);
        check("sat_fill", fill_s, 4);
        count_clr = 1'b1;
        cycle(1'b0, 1'b0);
        check("clr_nohit_count", count_s, 0);
        check("clr_nohit_match", match_s, 0);
        cycle(1'b1, 1'b1);
        count_clr = 1'b0;
        check("clr_hit_count", count_s, 1);
        check("clr_hit_match", match_s, 1);

        // Mid-stream reset discards history and the loaded pattern.
        overlap = 1'b1;
        do_load(4'b1010, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("pre_reset_fill", fill, 3);
        do_reset();
        check("midrst_fill", fill, 0);
        check("midrst_match", match, 0);
        check("midrst_count", match_count, 0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 1'b1);
            check($sformatf("midrst_ones_match_%0d", k), match, (k == 4) ? 1 : 0);
        end
        check("midrst_count_end", match_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
